// File: rtl/user_io_ctrl.sv
// -----------------------------------------------------------------------------
// user_io_ctrl
//   User-I/O controller for the dev-kit push-buttons, DIP switches and LEDs,
//   presented to the Nios II as an Avalon-MM slave with a read latency of 1.
//   Every button and switch bit goes through a 2-FF synchroniser and a
//   debouncer. Accepted changes are latched into a W1C EDGE register, and
//   irq is a registered OR of EDGE & MASK. LEDs are driven from a register.
//
//   Optional feature: define LED_BLINK_EN to build the blink divider and the
//   per-LED blink-enable bits. Without it the LEDs are static and LED[31:16]
//   reads 0.
//
// Ports
//   CLK_50_MAX10   in   sole clock
//   CPU_RESETn     in   synchronous reset, active-low
//   USER_PB        in   raw push-buttons, asynchronous, low = pressed
//   USER_DIPSW     in   raw DIP switches, asynchronous
//   USER_LED       out  LED pins, polarity set by LED_ACTIVE_LOW
//   avs_address    in   word address: 0 LED, 1 STATUS, 2 EDGE, 3 MASK
//   avs_read       in   read strobe
//   avs_write      in   write strobe
//   avs_writedata  in   write data
//   avs_readdata   out  read data, valid the cycle after avs_read, then held
//   irq            out  level interrupt, registered
// -----------------------------------------------------------------------------
module user_io_ctrl #(
    parameter int N_PB            = 4,
    parameter int N_DIPSW         = 5,
    parameter int N_LED           = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int LED_ACTIVE_LOW  = 1,
    parameter int BLINK_DIV       = 12500000
) (
    input  logic               CLK_50_MAX10,
    input  logic               CPU_RESETn,
    input  logic [N_PB-1:0]    USER_PB,
    input  logic [N_DIPSW-1:0] USER_DIPSW,
    output logic [N_LED-1:0]   USER_LED,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic               irq
);

    // Buttons and switches share one internal vector: {dip, pb}.
    localparam int N_IN   = N_PB + N_DIPSW;
    localparam int INIT_W = CNT_W + 1;

    localparam logic [CNT_W-1:0]  DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [INIT_W-1:0] INIT_DONE  = INIT_W'(DEBOUNCE_CYCLES + 2);
    // Buttons idle high (released), switches idle low.
    localparam logic [N_IN-1:0]   STABLE_RST = {{N_DIPSW{1'b0}}, {N_PB{1'b1}}};
    localparam logic [N_LED-1:0]  PIN_RST    = (LED_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic [1:0] {
        REG_LED    = 2'd0,
        REG_STATUS = 2'd1,
        REG_EDGE   = 2'd2,
        REG_MASK   = 2'd3
    } reg_addr_e;

    // Internal {dip, pb} vector <-> bus layout (pb at [N_PB-1:0], dip at [16+:N_DIPSW]).
    function automatic logic [31:0] to_bus(input logic [N_IN-1:0] v);
        logic [31:0] w;
        w              = '0;
        w[N_PB-1:0]    = v[N_PB-1:0];
        w[16+:N_DIPSW] = v[N_IN-1:N_PB];
        return w;
    endfunction

    function automatic logic [N_IN-1:0] from_bus(input logic [31:0] w);
        return {w[16+:N_DIPSW], w[N_PB-1:0]};
    endfunction

    logic [N_IN-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_IN-1:0]   stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q [N_IN];
    logic [CNT_W-1:0]  cnt_d [N_IN];
    logic [INIT_W-1:0] init_q, init_d;
    logic [N_IN-1:0]   edge_q, edge_d, mask_q, mask_d;
    logic [N_LED-1:0]  led_q, led_d, pin_q, pin_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic [N_IN-1:0]   changed, edge_set, edge_clr;
    logic [N_LED-1:0]  led_shown;
    logic [31:0]       led_rb;
    logic              wr_led, wr_edge, wr_mask;

`ifdef LED_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_DIV + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [N_LED-1:0]   blink_q, blink_d;
    logic [BLINK_W-1:0] bcnt_q, bcnt_d;
    logic               phase_q, phase_d;
`else
    localparam int unused_blink_div = BLINK_DIV;
`endif

    // Which write-data bits matter depends on the parameters; the rest are dropped.
    logic unused_wdata;
    assign unused_wdata = ^avs_writedata;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can leave it unassigned and infer a latch.
        sync1_d   = {USER_DIPSW, USER_PB};
        sync2_d   = sync1_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        init_d    = (init_q == INIT_DONE) ? init_q : init_q + 1'b1;
        wr_led    = avs_write && (reg_addr_e'(avs_address) == REG_LED);
        wr_edge   = avs_write && (reg_addr_e'(avs_address) == REG_EDGE);
        wr_mask   = avs_write && (reg_addr_e'(avs_address) == REG_MASK);
        led_d     = wr_led ? avs_writedata[N_LED-1:0] : led_q;
        mask_d    = wr_mask ? from_bus(avs_writedata) : mask_q;
        led_shown = led_q;
        led_rb    = '0;
        led_rb[N_LED-1:0] = led_q;

        // Debounce: a bit must differ from its stable value for DEBOUNCE_CYCLES
        // consecutive cycles; any return to the stable value restarts the count.
        for (int i = 0; i < N_IN; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end

        // Buttons report a press (stable 1->0), switches report any change.
        // Nothing is captured until the power-up window has elapsed.
        changed  = stable_q ^ stable_d;
        edge_set = {changed[N_IN-1:N_PB], changed[N_PB-1:0] & stable_q[N_PB-1:0]};
        if (init_q != INIT_DONE) begin
            edge_set = '0;
        end
        edge_clr = wr_edge ? from_bus(avs_writedata) : '0;
        // Set is applied after clear so a new edge survives a simultaneous W1C.
        edge_d   = (edge_q & ~edge_clr) | edge_set;

        irq_d = |(edge_q & mask_q);

`ifdef LED_BLINK_EN
        blink_d   = wr_led ? avs_writedata[16+:N_LED] : blink_q;
        bcnt_d    = (bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 1'b1;
        phase_d   = (bcnt_q == BLINK_LAST) ? ~phase_q : phase_q;
        led_shown = led_q & (~blink_q | {N_LED{phase_q}});
        led_rb[16+:N_LED] = blink_q;
`endif
        pin_d = (LED_ACTIVE_LOW != 0) ? ~led_shown : led_shown;

        // Reads see the registers before this cycle's write lands.
        rdata_d = rdata_q;
        if (avs_read) begin
            case (reg_addr_e'(avs_address))
                REG_LED:    rdata_d = led_rb;
                REG_STATUS: rdata_d = to_bus({stable_q[N_IN-1:N_PB], ~stable_q[N_PB-1:0]});
                REG_EDGE:   rdata_d = to_bus(edge_q);
                REG_MASK:   rdata_d = to_bus(mask_q);
            endcase
        end
    end

    always_ff @(posedge CLK_50_MAX10) begin
        // NOTE: non-blocking assignments here so every flop samples the pre-edge value of every other flop.
        if (!CPU_RESETn) begin
            sync1_q  <= STABLE_RST;
            sync2_q  <= STABLE_RST;
            stable_q <= STABLE_RST;
            // NOTE: the debounce counters are reset too; a stale count would accept a change early after reset.
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
            init_q   <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            led_q    <= '0;
            pin_q    <= PIN_RST;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
`ifdef LED_BLINK_EN
            blink_q  <= '0;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
`endif
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            led_q    <= led_d;
            pin_q    <= pin_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
`ifdef LED_BLINK_EN
            blink_q  <= blink_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
`endif
        end
    end

    assign USER_LED     = pin_q;
    assign avs_readdata = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_user_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_user_io_ctrl
//   Self-checking bench for user_io_ctrl with DEBOUNCE_CYCLES=8, BLINK_DIV=4.
//   Inputs are driven on the falling edge; outputs are sampled on the
//   following falling edge. Expected read data goes into a queue when the
//   read is issued and is popped when avs_readdata becomes valid.
//   DIP switch 0 is held on from reset, so its power-up acceptance must not
//   produce an edge, and STATUS[16] reads 1 afterwards.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_user_io_ctrl;
    localparam int N_PB = 4, N_DIPSW = 5, N_LED = 5;
    localparam logic [1:0] A_LED = 2'd0, A_STATUS = 2'd1, A_EDGE = 2'd2, A_MASK = 2'd3;
    localparam logic [31:0] DIP0 = 32'h0001_0000;
`ifdef LED_BLINK_EN
    localparam logic [31:0] BLINK_RB = 32'h001F_0000;
    localparam logic [31:0] LED6_RB  = 32'h0001_0015;
`else
    localparam logic [31:0] BLINK_RB = 32'h0000_0000;
    localparam logic [31:0] LED6_RB  = 32'h0000_0015;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_PB-1:0]    user_pb;
    logic [N_DIPSW-1:0] user_dipsw;
    logic [N_LED-1:0]   user_led;
    logic [1:0]         avs_address;
    logic               avs_read, avs_write;
    logic [31:0]        avs_writedata, avs_readdata;
    logic               irq;

    user_io_ctrl #(
        .N_PB(N_PB), .N_DIPSW(N_DIPSW), .N_LED(N_LED),
        .DEBOUNCE_CYCLES(8), .CNT_W(20), .LED_ACTIVE_LOW(1), .BLINK_DIV(4)
    ) dut (
        .CLK_50_MAX10 (clk),
        .CPU_RESETn   (rst_n),
        .USER_PB      (user_pb),
        .USER_DIPSW   (user_dipsw),
        .USER_LED     (user_led),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata (avs_readdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;   // write data, or expected read data
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        cyc();
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        sb_t e;
        sb.push_back('{exp, name});
        avs_address = a;
        avs_read    = 1'b1;
        cyc();
        avs_read    = 1'b0;
        e = sb.pop_front();
        check(e.name, avs_readdata, e.exp);
    endtask

    task automatic rdwr(input logic [1:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
        sb_t e;
        sb.push_back('{exp, name});
        avs_address   = a;
        avs_writedata = d;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        cyc();
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        e = sb.pop_front();
        check(e.name, avs_readdata, e.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        int   toggles;
        logic prev;

        vecs[0]  = '{1'b0, A_LED,    32'h0000_0000, "rst_led"};
        vecs[1]  = '{1'b0, A_STATUS, 32'h0000_0000, "rst_status"};
        vecs[2]  = '{1'b0, A_EDGE,   32'h0000_0000, "rst_edge"};
        vecs[3]  = '{1'b0, A_MASK,   32'h0000_0000, "rst_mask"};
        vecs[4]  = '{1'b1, A_MASK,   32'hFFFF_FFFF, "wr_mask_all"};
        vecs[5]  = '{1'b0, A_MASK,   32'h001F_000F, "mask_unused_bits"};
        vecs[6]  = '{1'b1, A_STATUS, 32'hFFFF_FFFF, "wr_status_ro"};
        vecs[7]  = '{1'b0, A_STATUS, 32'h0000_0000, "status_ro"};
        vecs[8]  = '{1'b1, A_MASK,   32'h0000_0001, "wr_mask_pb0"};
        vecs[9]  = '{1'b0, A_MASK,   32'h0000_0001, "mask_pb0"};
        vecs[10] = '{1'b1, A_LED,    32'hFFFF_FFE0, "wr_led_hi"};
        vecs[11] = '{1'b0, A_LED,    BLINK_RB,      "led_hi_bits"};
        vecs[12] = '{1'b1, A_LED,    32'h0000_0000, "wr_led_zero"};

        rst_n         = 1'b0;
        user_pb       = '1;
        user_dipsw    = 5'b00001;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        repeat (3) cyc();
        check("rst_pins", 32'(user_led), 32'h1F);
        check("rst_rdata", avs_readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;

        // Register access during the init window; irq must stay low throughout.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
            else            rd(vecs[i].addr, vecs[i].data, vecs[i].name);
            check("init_irq", 32'(irq), 32'h0);
        end
        check("init_pins", 32'(user_led), 32'h1F);
        repeat (4) begin
            cyc();
            check("init_irq_tail", 32'(irq), 32'h0);
        end
        rd(A_EDGE, 32'h0, "init_edge_suppressed");
        rd(A_STATUS, DIP0, "init_status_dip0");

        // Press PB[0]: accepted at cycle 10, irq one cycle later.
        user_pb[0] = 1'b0;
        repeat (9) cyc();
        rd(A_STATUS, DIP0, "pb0_status_c10_old");
        check("pb0_irq_c10", 32'(irq), 32'h0);
        rd(A_STATUS, DIP0 | 32'h1, "pb0_status_c11");
        check("pb0_irq_c11", 32'(irq), 32'h1);
        rd(A_EDGE, 32'h1, "pb0_edge");
        user_pb[0] = 1'b1;
        wr(A_EDGE, 32'h1);
        check("clr_irq_lag", 32'(irq), 32'h1);
        cyc();
        check("clr_irq_drop", 32'(irq), 32'h0);
        rd(A_EDGE, 32'h0, "clr_edge");
        repeat (12) cyc();
        rd(A_STATUS, DIP0, "pb0_released");

        // New press accepted in the same cycle as a W1C: the set wins.
        user_pb[0] = 1'b0;
        repeat (9) cyc();
        wr(A_EDGE, 32'h1);
        rd(A_EDGE, 32'h1, "set_beats_clear");
        check("set_clr_irq", 32'(irq), 32'h1);
        wr(A_EDGE, 32'h1);
        check("clr2_irq_lag", 32'(irq), 32'h1);
        cyc();
        check("clr2_irq_drop", 32'(irq), 32'h0);
        rd(A_EDGE, 32'h0, "clr2_edge");
        user_pb[0] = 1'b1;
        repeat (12) cyc();

        // Short PB[1] glitches never get accepted.
        wr(A_MASK, 32'h001F_000F);
        repeat (3) begin
            user_pb[1] = 1'b0;
            repeat (5) begin
                cyc();
                check("glitch_irq", 32'(irq), 32'h0);
            end
            user_pb[1] = 1'b1;
            repeat (5) begin
                cyc();
                check("glitch_irq", 32'(irq), 32'h0);
            end
        end
        repeat (12) cyc();
        check("glitch_irq_after", 32'(irq), 32'h0);
        rd(A_STATUS, DIP0, "glitch_status");
        rd(A_EDGE, 32'h0, "glitch_edge");

        // DIP[4] rise then fall, 20 cycles each: an edge on both changes.
        user_dipsw = 5'b10001;
        repeat (14) cyc();
        rd(A_STATUS, 32'h0011_0000, "dip4_status_on");
        rd(A_EDGE, 32'h0010_0000, "dip4_edge_rise");
        check("dip4_irq_rise", 32'(irq), 32'h1);
        wr(A_EDGE, 32'h0010_0000);
        repeat (3) cyc();
        check("dip4_irq_cleared", 32'(irq), 32'h0);
        user_dipsw = 5'b00001;
        repeat (14) cyc();
        rd(A_STATUS, DIP0, "dip4_status_off");
        rd(A_EDGE, 32'h0010_0000, "dip4_edge_fall");
        wr(A_EDGE, 32'h0010_0000);
        repeat (3) cyc();
        rd(A_EDGE, 32'h0, "dip4_edge_cleared");

        // LEDs: pins follow the register one cycle after the write, inverted.
        check("led_pre", 32'(user_led), 32'h1F);
        wr(A_LED, 32'h0001_0015);
        check("led_lag", 32'(user_led), 32'h1F);
        cyc();
`ifdef LED_BLINK_EN
        check("led_steady_bits", 32'(user_led[4:1]), 32'h5);
        rd(A_LED, LED6_RB, "led_readback");
        prev    = user_led[0];
        toggles = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (user_led[0] != prev) toggles++;
            prev = user_led[0];
            check("led_steady_bits", 32'(user_led[4:1]), 32'h5);
        end
        check("led_blink_toggles", 32'(toggles), 32'd4);
`else
        check("led_pins", 32'(user_led), 32'h0A);
        rd(A_LED, LED6_RB, "led_readback");
        prev    = 1'b0;
        toggles = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("led_static", 32'(user_led), 32'h0A);
        end
`endif

        // Read and write in the same cycle: read returns the old value.
        rdwr(A_MASK, 32'h0000_0003, 32'h001F_000F, "rdwr_old_value");
        rd(A_MASK, 32'h0000_0003, "rdwr_new_value");

        // Reset mid-operation: everything returns to reset and init restarts.
        rst_n = 1'b0;
        repeat (2) cyc();
        check("mid_rst_rdata", avs_readdata, 32'h0);
        check("mid_rst_pins", 32'(user_led), 32'h1F);
        check("mid_rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        rd(A_LED, 32'h0, "mid_rst_led");
        rd(A_MASK, 32'h0, "mid_rst_mask");
        repeat (12) cyc();
        rd(A_EDGE, 32'h0, "mid_rst_edge_suppressed");
        rd(A_STATUS, DIP0, "mid_rst_status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
